nios2_nn_cpu_ocimem_monitor: RTL and testbench

//  System-clock consumer of the debug-slave command strobes (jdo + take_*_ocimem_*).

---
 rtl/nios2_nn_cpu_ocimem_monitor.sv | 173 +++++++++++++++++
 tb/tb_nios2_nn_cpu_ocimem_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_nn_cpu_ocimem_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------------+
// | nios2_nn_cpu_ocimem_monitor: debug monitor RAM, MonAReg/MonDReg and flags,     |
// | shared between JTAG command strobes and the CPU debug-memory slave. Rev 1.0    |
// +--------------------------------------------------------------------------------+
module nios2_nn_cpu_ocimem_monitor #(
    parameter int ADDR_W   = 8,
    parameter int MONA_RST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go,
    output logic              jtag_overrun
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        J_RD_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   monareg_q, monareg_d;
    logic [31:0]         mondreg_q, mondreg_d;
    logic                ready_q, ready_d, error_q, error_d, go_q, go_d;
    logic                overrun_q, overrun_d;
    logic                rdvalid_q, rdvalid_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         jq_q;
    logic                jrd_en;
    logic [ADDR_W-1:0]   jrd_addr;
    logic [3:0]          ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [31:0]         ram_wdata;

    logic                take_any, cpu_wr, cpu_rd, cpu_ctrl;
    logic [ADDR_W-1:0]   cpu_addr;
    logic                unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Any strobe claims the RAM for its cycle, so the CPU is stalled even if the strobe is dropped.
    assign take_any        = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign avs_waitrequest = take_any | rdvalid_q;
    assign cpu_wr          = avs_write & ~avs_waitrequest;
    assign cpu_rd          = avs_read & ~avs_write & ~avs_waitrequest;
    assign cpu_ctrl        = avs_address[ADDR_W];
    assign cpu_addr        = avs_address[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        monareg_d = monareg_q;
        mondreg_d = mondreg_q;
        ready_d   = ready_q;
        error_d   = error_q;
        go_d      = go_q;
        overrun_d = overrun_q;
        rdvalid_d = cpu_rd;
        rdata_d   = rdata_q;
        jrd_en    = 1'b0;
        jrd_addr  = monareg_q;
        ram_we    = 4'h0;
        ram_waddr = cpu_addr;
        ram_wdata = avs_writedata;

        if (state_q == J_RD_WAIT) begin
            mondreg_d = jq_q;
            state_d   = IDLE;
            if (take_any) begin
                overrun_d = 1'b1;
            end
        end else if (take_action_ocimem_b) begin
            ram_we    = 4'hF;
            ram_waddr = monareg_q;
            ram_wdata = jdo[34:3];
            mondreg_d = jdo[34:3];
            monareg_d = monareg_q + ADDR_W'(1);
        end else if (take_action_ocimem_a) begin
            if (!jdo[35]) begin
                monareg_d = jdo[ADDR_W+25:26];
                if (jdo[34]) begin
                    jrd_en   = 1'b1;
                    jrd_addr = jdo[ADDR_W+25:26];
                    state_d  = J_RD_WAIT;
                end
            end else begin
                if (jdo[25]) ready_d = 1'b0;
                if (jdo[24]) error_d = 1'b0;
                if (jdo[23]) go_d    = 1'b1;
            end
        end else if (take_no_action_ocimem_a) begin
            jrd_en    = 1'b1;
            monareg_d = monareg_q + ADDR_W'(1);
            state_d   = J_RD_WAIT;
        end

        // CPU accesses never coincide with a strobe, so they cannot collide with the JTAG updates above.
        if (cpu_wr) begin
            if (cpu_ctrl) begin
                if (avs_writedata[0]) ready_d = 1'b1;
                if (avs_writedata[1]) error_d = 1'b1;
                if (avs_writedata[2]) go_d    = 1'b0;
            end else begin
                ram_we = avs_byteenable;
            end
        end
        if (cpu_rd) begin
            rdata_d = cpu_ctrl ? {29'b0, go_q, error_q, ready_q} : mem[cpu_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            monareg_q <= ADDR_W'(MONA_RST);
            mondreg_q <= 32'h0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            go_q      <= 1'b0;
            overrun_q <= 1'b0;
            rdvalid_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            monareg_q <= monareg_d;
            mondreg_q <= mondreg_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            go_q      <= go_d;
            overrun_q <= overrun_d;
            rdvalid_q <= rdvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // RAM contents survive reset; only writes issued during reset are suppressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (jrd_en) jq_q <= mem[jrd_addr];
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rdvalid_q;
    assign MonDReg           = mondreg_q;
    assign monitor_ready     = ready_q;
    assign monitor_error     = error_q;
    assign monitor_go        = go_q;
    assign jtag_overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2_nn_cpu_ocimem_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for nios2_nn_cpu_ocimem_monitor: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural monitor model.
module tb_nios2_nn_cpu_ocimem_monitor;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [AW:0] avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go, jtag_overrun;

    nios2_nn_cpu_ocimem_monitor #(.ADDR_W(AW), .MONA_RST(0)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_waitrequest         (avs_waitrequest),
        .avs_readdata            (avs_readdata),
        .avs_readdatavalid       (avs_readdatavalid),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go),
        .jtag_overrun            (jtag_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state after the most recent clock edge.
    bit          model_on = 0;
    int          m_ma;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_mond, m_rdata, m_jdata;
    bit          m_rdy, m_err, m_go, m_ovr, m_rdv, m_jpend;
    bit          s_take, s_accw, s_accr, s_ctrl;
    int          s_a;

    always @(posedge clk) begin
        s_take = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
        if (reset) begin
            model_on = 1;
            m_ma = 0; m_mond = 0; m_rdata = 0;
            m_rdy = 0; m_err = 0; m_go = 0; m_ovr = 0; m_rdv = 0; m_jpend = 0;
        end else begin
            s_accw = avs_write && !(s_take || m_rdv);
            s_accr = avs_read && !avs_write && !(s_take || m_rdv);
            s_ctrl = avs_address[AW];
            s_a    = int'(avs_address[AW-1:0]);
            m_rdv  = s_accr;
            if (s_accr) m_rdata = s_ctrl ? {29'b0, m_go, m_err, m_rdy} : m_mem[s_a];
            if (m_jpend) begin
                m_mond  = m_jdata;
                m_jpend = 0;
                if (s_take) m_ovr = 1;
            end else if (take_action_ocimem_b) begin
                m_mem[m_ma] = jdo[34:3];
                m_mond = jdo[34:3];
                m_ma = (m_ma + 1) % DEPTH;
            end else if (take_action_ocimem_a) begin
                if (jdo[35] == 1'b0) begin
                    m_ma = int'(jdo[33:26]);
                    if (jdo[34]) begin m_jpend = 1; m_jdata = m_mem[m_ma]; end
                end else begin
                    if (jdo[25]) m_rdy = 0;
                    if (jdo[24]) m_err = 0;
                    if (jdo[23]) m_go  = 1;
                end
            end else if (take_no_action_ocimem_a) begin
                m_jpend = 1;
                m_jdata = m_mem[m_ma];
                m_ma = (m_ma + 1) % DEPTH;
            end
            if (s_accw) begin
                if (s_ctrl) begin
                    if (avs_writedata[0]) m_rdy = 1;
                    if (avs_writedata[1]) m_err = 1;
                    if (avs_writedata[2]) m_go  = 0;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (avs_byteenable[b]) m_mem[s_a][8*b +: 8] = avs_writedata[8*b +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("MonDReg", MonDReg, m_mond);
            check("monitor_ready", {31'b0, monitor_ready}, {31'b0, m_rdy});
            check("monitor_error", {31'b0, monitor_error}, {31'b0, m_err});
            check("monitor_go", {31'b0, monitor_go}, {31'b0, m_go});
            check("jtag_overrun", {31'b0, jtag_overrun}, {31'b0, m_ovr});
            check("readdatavalid", {31'b0, avs_readdatavalid}, {31'b0, m_rdv});
            if (m_rdv) check("readdata", avs_readdata, m_rdata);
            check("waitrequest", {31'b0, avs_waitrequest},
                  {31'b0, (take_action_ocimem_a || take_action_ocimem_b ||
                           take_no_action_ocimem_a || m_rdv)});
        end
    end

    function automatic logic [37:0] mk_addr(input int addr, input bit rd);
        logic [37:0] v = '0;
        v[34] = rd;
        v[33:26] = addr[7:0];
        return v;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] v = '0;
        v[34:3] = data;
        return v;
    endfunction

    function automatic logic [37:0] mk_ctrl(input bit clr_r, input bit clr_e, input bit set_g);
        logic [37:0] v = '0;
        v[35] = 1'b1;
        v[25] = clr_r;
        v[24] = clr_e;
        v[23] = set_g;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int which, input logic [37:0] d);
        jdo = d;
        take_action_ocimem_a    = (which == 0);
        take_action_ocimem_b    = (which == 1);
        take_no_action_ocimem_a = (which == 2);
        tick();
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    endtask

    task automatic cpu_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
        bit done = 0;
        avs_write = 1; avs_address = addr; avs_writedata = data; avs_byteenable = be;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            done = !avs_waitrequest;
            tick();
        end
        avs_write = 0;
        if (!done) check("cpu_write accepted", 32'd0, 32'd1);
    endtask

    task automatic cpu_read(input logic [8:0] addr, output logic [31:0] data);
        bit done = 0;
        avs_read = 1; avs_address = addr;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            done = !avs_waitrequest;
            tick();
        end
        avs_read = 0;
        if (!done) check("cpu_read accepted", 32'd0, 32'd1);
        @(negedge clk);
        check("cpu_read valid", {31'b0, avs_readdatavalid}, 32'd1);
        data = avs_readdata;
        tick();
    endtask

    task automatic expect_now(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        check(name, act_sel, exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;
    logic [63:0] rj;
    int          r, c;

    initial begin
        reset = 1; jdo = '0;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
        repeat (3) tick();
        @(negedge clk);
        expect_now("reset MonDReg", MonDReg, 32'h0);
        expect_now("reset flags", {28'b0, jtag_overrun, monitor_go, monitor_error, monitor_ready}, 32'h0);
        expect_now("reset readdatavalid", {31'b0, avs_readdatavalid}, 32'h0);
        expect_now("reset readdata", avs_readdata, 32'h0);
        tick();
        reset = 0;

        for (int a = 0; a < DEPTH; a++) cpu_write(9'(a), $urandom(), 4'hF);

        // Address load, write, then verify the increment by reading the next word.
        strobe(0, mk_addr(32'h10, 0));
        strobe(1, mk_b(32'hDEADBEEF));
        @(negedge clk); expect_now("T1 MonDReg after write", MonDReg, 32'hDEADBEEF); tick();
        cpu_write(9'h011, 32'h0000_1111, 4'hF);
        strobe(2, '0); tick();
        @(negedge clk); expect_now("T1 MonAReg incremented", MonDReg, 32'h0000_1111); tick();

        strobe(0, mk_addr(32'h10, 1));
        @(negedge clk); expect_now("T2 early MonDReg held", MonDReg, 32'h0000_1111); tick();
        @(negedge clk); expect_now("T2 addr-load read", MonDReg, 32'hDEADBEEF); tick();
        strobe(2, '0); tick();
        @(negedge clk); expect_now("T2 no-increment read", MonDReg, 32'hDEADBEEF); tick();
        strobe(2, '0); tick();
        @(negedge clk); expect_now("T2 post-increment read", MonDReg, 32'h0000_1111); tick();

        cpu_write(9'h000, 32'h0000_0ABC, 4'hF);
        strobe(0, mk_addr(32'hFF, 0));
        strobe(1, mk_b(32'hCAFEF00D));
        strobe(2, '0); tick();
        @(negedge clk); expect_now("T3 MonAReg wrap", MonDReg, 32'h0000_0ABC); tick();
        cpu_read(9'h0FF, rd);
        expect_now("T3 cpu read 0xFF", rd, 32'hCAFEF00D);

        cpu_write(9'h100, 32'h3, 4'hF);
        @(negedge clk); expect_now("T4 cpu set flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h3); tick();
        strobe(0, mk_ctrl(1, 0, 0));
        @(negedge clk); expect_now("T4 jtag clear ready", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h2); tick();
        strobe(0, mk_ctrl(0, 0, 1));
        @(negedge clk); expect_now("T4 jtag set go", {31'b0, monitor_go}, 32'h1); tick();
        cpu_read(9'h100, rd);
        expect_now("T4 ctrl readback", rd, 32'h6);
        cpu_write(9'h100, 32'h4, 4'hF);
        @(negedge clk); expect_now("T4 cpu clear go", {31'b0, monitor_go}, 32'h0); tick();

        // CPU write colliding with a JTAG strobe must stall one cycle.
        avs_write = 1; avs_address = 9'h020; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
        jdo = mk_ctrl(0, 0, 0); take_action_ocimem_a = 1;
        @(negedge clk); expect_now("T5 waitrequest on strobe", {31'b0, avs_waitrequest}, 32'h1);
        tick();
        take_action_ocimem_a = 0;
        @(negedge clk); expect_now("T5 waitrequest released", {31'b0, avs_waitrequest}, 32'h0);
        tick();
        avs_write = 0;
        cpu_read(9'h020, rd);
        expect_now("T5 stalled write landed", rd, 32'h1234_5678);
        cpu_write(9'h020, 32'hAABB_CCDD, 4'b0101);
        cpu_read(9'h020, rd);
        expect_now("T5 byte-lane merge", rd, 32'h12BB_56DD);

        take_no_action_ocimem_a = 1; tick(); tick(); take_no_action_ocimem_a = 0;
        @(negedge clk); expect_now("T6 overrun set", {31'b0, jtag_overrun}, 32'h1); tick();
        strobe(2, '0);
        reset = 1; tick(); reset = 0; tick();
        @(negedge clk); expect_now("T6 reset aborts read", MonDReg, 32'h0);
        expect_now("T6 overrun cleared", {31'b0, jtag_overrun}, 32'h0); tick();

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            rj = {$urandom(), $urandom()};
            jdo = rj[37:0];
            take_action_ocimem_a    = (r >= 6 && r < 12) || (r >= 18 && r < 20);
            take_action_ocimem_b    = (r >= 12 && r < 18) || r == 18;
            take_no_action_ocimem_a = (r < 6) || r == 19;
            c = $urandom_range(0, 9);
            avs_read       = (c <= 3) || c == 7;
            avs_write      = (c >= 4 && c <= 7);
            avs_address    = 9'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) avs_address[8] = 1'b1;
            avs_writedata  = $urandom();
            avs_byteenable = 4'($urandom_range(0, 15));
            reset          = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0; avs_read = 0; avs_write = 0;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
